// File: rtl/vga_rect_ctrl.sv
// Four-rectangle VGA overlay with shadow/active double buffering.
// A commit publishes the whole shadow set at the next frame start.
module vga_rect_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [9:0] X,
    input  logic [9:0] Y,
    input  logic       WR_VALID,
    output logic       WR_READY,
    input  logic [1:0] WR_SLOT,
    input  logic [2:0] WR_FIELD,
    input  logic [9:0] WR_DATA,
    input  logic       COMMIT,
    output logic       COMMIT_BUSY,
    output logic [7:0] FRAME_CNT,
    output logic [2:0] RED,
    output logic [2:0] GREEN,
    output logic [1:0] BLUE
);
    typedef struct packed {
        logic [9:0] x0;
        logic [9:0] x1;
        logic [9:0] y0;
        logic [9:0] y1;
        logic       en;
        logic [7:0] col;
    } rect_t;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        APPLY
    } state_t;

    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

    state_t      state_q, state_d;
    rect_t [3:0] shadow_q;
    rect_t [3:0] active_q;
    logic [19:0] prev_xy_q;
    logic [7:0]  frame_cnt_q;
    logic [7:0]  color_q, color_d;
    logic [3:0]  hit;
    logic        frame_start;
    logic        wr_fire;

    // Edge on entering {0,0}, independent of how long the pixel is held.
    assign frame_start = ({X, Y} == 20'd0) && (prev_xy_q != 20'd0);
    assign wr_fire     = WR_VALID && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (COMMIT) state_d = PENDING;
            PENDING: if (frame_start) state_d = APPLY;
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            prev_xy_q   <= '0;
            frame_cnt_q <= '0;
            color_q     <= '0;
        end else begin
            state_q     <= state_d;
            prev_xy_q   <= {X, Y};
            color_q     <= color_d;
            if (frame_start) frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow_q <= '0;
        end else if (wr_fire) begin
            case (WR_FIELD)
                3'd0: shadow_q[WR_SLOT].x0 <= WR_DATA;
                3'd1: shadow_q[WR_SLOT].x1 <= WR_DATA;
                3'd2: shadow_q[WR_SLOT].y0 <= WR_DATA;
                3'd3: shadow_q[WR_SLOT].y1 <= WR_DATA;
                3'd4: begin
                    shadow_q[WR_SLOT].en  <= WR_DATA[8];
                    shadow_q[WR_SLOT].col <= WR_DATA[7:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            active_q <= '0;
        end else if (state_q == APPLY) begin
            active_q <= shadow_q;
        end
    end

    // Walk from lowest priority up so slot 0 wins overlaps.
    always_comb begin
        hit     = '0;
        color_d = '0;
        for (int k = 3; k >= 0; k--) begin
            hit[k] = active_q[k].en
                  && (X >= active_q[k].x0) && (X < active_q[k].x1)
                  && (Y >= active_q[k].y0) && (Y < active_q[k].y1);
            if (hit[k]) color_d = active_q[k].col;
        end
        if (({1'b0, X} >= H_LIM) || ({1'b0, Y} >= V_LIM)) color_d = '0;
    end

    assign WR_READY    = (state_q == IDLE);
    assign COMMIT_BUSY = (state_q != IDLE);
    assign FRAME_CNT   = frame_cnt_q;
    assign RED         = color_q[7:5];
    assign GREEN       = color_q[4:2];
    assign BLUE        = color_q[1:0];
endmodule

// File: tb/tb_vga_rect_ctrl.sv
// Bench for vga_rect_ctrl: directed sequences, pixel table and
// randomized traffic against a frame-level reference model.
module tb_vga_rect_ctrl;
    logic       CLK = 1'b0;
    logic       RST_N;
    logic [9:0] X, Y;
    logic       WR_VALID, WR_READY;
    logic [1:0] WR_SLOT;
    logic [2:0] WR_FIELD;
    logic [9:0] WR_DATA;
    logic       COMMIT, COMMIT_BUSY;
    logic [7:0] FRAME_CNT;
    logic [2:0] RED, GREEN;
    logic [1:0] BLUE;

    vga_rect_ctrl #(.H_ACTIVE(640), .V_ACTIVE(480)) dut (
        .CLK(CLK), .RST_N(RST_N), .X(X), .Y(Y),
        .WR_VALID(WR_VALID), .WR_READY(WR_READY),
        .WR_SLOT(WR_SLOT), .WR_FIELD(WR_FIELD), .WR_DATA(WR_DATA),
        .COMMIT(COMMIT), .COMMIT_BUSY(COMMIT_BUSY),
        .FRAME_CNT(FRAME_CNT), .RED(RED), .GREEN(GREEN), .BLUE(BLUE)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int x0, x1, y0, y1, en, col;
    } mrect_t;

    typedef struct {
        int x, y, col;
    } vec_t;

    mrect_t sh[4];
    mrect_t ac[4];
    int m_busy, m_apply, m_fc, m_px, m_py, m_col;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_col(input string nm, input int exp);
        check(nm, int'({RED, GREEN, BLUE}), exp);
    endtask

    function automatic int pix(input int x, input int y);
        if (x >= 640 || y >= 480) return 0;
        for (int k = 0; k < 4; k++)
            if (ac[k].en != 0 && ac[k].x0 <= x && x < ac[k].x1 &&
                ac[k].y0 <= y && y < ac[k].y1)
                return ac[k].col;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            sh[k] = '{0, 0, 0, 0, 0, 0};
            ac[k] = '{0, 0, 0, 0, 0, 0};
        end
        m_busy = 0; m_apply = 0; m_fc = 0;
        m_px = 0; m_py = 0; m_col = 0;
    endtask

    task automatic model_step(input int x, y, wv, slot, field, data, cm);
        int  col;
        bit  fs, rdy;
        col = pix(x, y);
        fs  = (x == 0 && y == 0) && !(m_px == 0 && m_py == 0);
        rdy = (m_busy == 0);
        m_px = x; m_py = y;
        if (fs) m_fc = (m_fc + 1) % 256;
        if (m_apply != 0) begin
            ac = sh;
            m_apply = 0;
            m_busy = 0;
        end else if (m_busy != 0 && fs) begin
            m_apply = 1;
        end
        if (rdy && wv != 0) begin
            case (field)
                0: sh[slot].x0 = data;
                1: sh[slot].x1 = data;
                2: sh[slot].y0 = data;
                3: sh[slot].y1 = data;
                4: begin
                    sh[slot].en  = (data >> 8) & 1;
                    sh[slot].col = data & 255;
                end
                default: ;
            endcase
        end
        if (rdy && cm != 0) m_busy = 1;
        m_col = col;
    endtask

    task automatic cyc(input int x, y, wv, slot, field, data, cm);
        @(negedge CLK);
        X = 10'(x); Y = 10'(y);
        WR_VALID = 1'(wv); WR_SLOT = 2'(slot);
        WR_FIELD = 3'(field); WR_DATA = 10'(data);
        COMMIT = 1'(cm);
        @(posedge CLK);
        model_step(x, y, wv, slot, field, data, cm);
        #1;
        chk_col("color", m_col);
        check("wr_ready", int'(WR_READY), (m_busy == 0) ? 1 : 0);
        check("commit_busy", int'(COMMIT_BUSY), m_busy);
        check("frame_cnt", int'(FRAME_CNT), m_fc);
    endtask

    task automatic px(input int x, y);
        cyc(x, y, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int slot, field, data);
        cyc(5, 5, 1, slot, field, data, 0);
    endtask

    task automatic wr_rect(input int s, x0, x1, y0, y1, attr);
        wr(s, 0, x0); wr(s, 1, x1); wr(s, 2, y0); wr(s, 3, y1); wr(s, 4, attr);
    endtask

    task automatic frame();
        px(1, 0);
        px(0, 0);
    endtask

    task automatic commit_apply();
        cyc(5, 5, 0, 0, 0, 0, 1);
        frame();
        px(5, 5);
    endtask

    task automatic drive_zero();
        X = '0; Y = '0; WR_VALID = 0; WR_SLOT = '0;
        WR_FIELD = '0; WR_DATA = '0; COMMIT = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[9];
        int   start_fc;

        tbl[0] = '{250, 200, 'hE0};
        tbl[1] = '{350, 200, 'h1C};
        tbl[2] = '{300, 300, 'h1C};
        tbl[3] = '{400, 350, 'h00};
        tbl[4] = '{639, 10,  'h03};
        tbl[5] = '{640, 10,  'h00};
        tbl[6] = '{650, 10,  'h00};
        tbl[7] = '{100, 400, 'h00};
        tbl[8] = '{299, 299, 'hE0};

        RST_N = 0;
        drive_zero();
        model_reset();
        #12;
        chk_col("rst_color", 0);
        check("rst_ready", int'(WR_READY), 1);
        check("rst_busy", int'(COMMIT_BUSY), 0);
        check("rst_fcnt", int'(FRAME_CNT), 0);
        @(negedge CLK);
        RST_N = 1;
        px(0, 0);
        check("no_fs_after_rst", int'(FRAME_CNT), 0);

        // Single red rectangle, visible only after the commit's frame start
        wr_rect(0, 0, 300, 0, 300, 'h1E0);
        cyc(10, 10, 0, 0, 0, 0, 1);
        chk_col("pre_commit", 0);
        check("busy_pending", int'(COMMIT_BUSY), 1);
        px(1, 0);
        px(0, 0);
        px(10, 10);
        chk_col("apply_old", 0);
        px(10, 10);
        chk_col("red_in", 'hE0);
        px(310, 10);
        chk_col("red_out", 0);
        frame();
        px(10, 299);
        chk_col("red_2nd_frame", 'hE0);

        // Overlap, edge and degenerate rectangles
        wr_rect(1, 200, 400, 150, 350, 'h11C);
        wr_rect(2, 600, 700, 0, 20, 'h103);
        wr_rect(3, 100, 100, 0, 480, 'h1FF);
        commit_apply();
        foreach (tbl[i]) begin
            px(tbl[i].x, tbl[i].y);
            chk_col($sformatf("tbl%0d", i), tbl[i].col);
        end

        // Write with commit, then a write held through the commit
        cyc(5, 5, 1, 0, 4, 'h103, 1);
        cyc(1, 0, 1, 0, 4, 'h1FF, 0);
        check("held_ready0", int'(WR_READY), 0);
        cyc(0, 0, 1, 0, 4, 'h1FF, 0);
        check("held_ready_fs", int'(WR_READY), 0);
        cyc(10, 10, 1, 0, 4, 'h1FF, 0);
        check("ready_after_apply", int'(WR_READY), 1);
        cyc(10, 10, 1, 0, 4, 'h1FF, 0);
        chk_col("same_cycle_write", 'h03);
        px(10, 10);
        chk_col("held_not_active", 'h03);
        commit_apply();
        px(10, 10);
        chk_col("held_after_commit", 'hFF);

        // Repeated COMMIT while pending
        cyc(5, 5, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(5, 5, 0, 0, 0, 0, 1);
            check("busy_repeat", int'(COMMIT_BUSY), 1);
        end
        frame();
        check("busy_in_apply", int'(COMMIT_BUSY), 1);
        px(5, 5);
        check("busy_cleared", int'(COMMIT_BUSY), 0);
        frame();
        check("no_second_apply", int'(COMMIT_BUSY), 0);

        // COMMIT on a frame start waits for the next one
        px(1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        px(10, 10);
        px(10, 10);
        check("fs_commit_pending", int'(COMMIT_BUSY), 1);
        frame();
        px(5, 5);
        check("fs_commit_done", int'(COMMIT_BUSY), 0);

        // Reset during PENDING aborts the commit
        wr(0, 4, 'h1E0);
        cyc(10, 10, 0, 0, 0, 0, 1);
        px(10, 10);
        @(negedge CLK);
        #2;
        RST_N = 0;
        drive_zero();
        #1;
        model_reset();
        chk_col("rst_mid_color", 0);
        check("rst_mid_busy", int'(COMMIT_BUSY), 0);
        check("rst_mid_ready", int'(WR_READY), 1);
        check("rst_mid_fcnt", int'(FRAME_CNT), 0);
        @(negedge CLK);
        RST_N = 1;
        frame();
        check("rst_no_apply", int'(COMMIT_BUSY), 0);
        px(10, 10);
        chk_col("rst_slots_clear", 0);

        // Frame counter wraps after 256 frame starts
        start_fc = m_fc;
        for (int i = 0; i < 256; i++) frame();
        check("fcnt_wrap", int'(FRAME_CNT), start_fc);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r, x, y, wv, sl, fd, dt, cm;
            r = $urandom_range(0, 9);
            if (r == 0) begin x = 0; y = 0; end
            else if (r == 1) begin x = 1; y = 0; end
            else begin
                x = $urandom_range(0, 700);
                y = $urandom_range(0, 520);
            end
            wv = $urandom_range(0, 1);
            sl = $urandom_range(0, 3);
            fd = $urandom_range(0, 7);
            dt = (fd == 4) ? $urandom_range(0, 1023) : $urandom_range(0, 700);
            cm = ($urandom_range(0, 15) == 0) ? 1 : 0;
            cyc(x, y, wv, sl, fd, dt, cm);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_rect_ctrl.md
VGA_RECT_CTRL -- requirements
Module: vga_rect_ctrl

Interface
REQ-001 The module SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The module SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- CLK  in  1  system clock; all logic rising-edge.
- RST_N  in  1  asynchronous reset, active-low.
REQ-004 The module SHALL have these ports:
- X  in  10  current pixel column from the VGA timing block.
- Y  in  10  current pixel line from the VGA timing block.
- WR_VALID  in  1  write request.
- WR_READY  out  1  write accepted when high with WR_VALID.
- WR_SLOT  in  2  rectangle slot 0..3.
- WR_FIELD  in  3  field select: 0=x0, 1=x1, 2=y0, 3=y1, 4=attr.
- WR_DATA  in  10  field value; for attr, [8]=enable and [7:0]={R3,G3,B2}.
- COMMIT  in  1  single-cycle request to publish shadow to active.
- COMMIT_BUSY  out  1  commit pending or applying.
- FRAME_CNT  out  8  frame-start counter.
- RED  out  3  pixel red.
- GREEN  out  3  pixel green.
- BLUE  out  2  pixel blue.

Function
REQ-005 The module SHALL hold 4 shadow slots and 4 active slots; each slot holds x0, x1, y0, y1 (10 bits each), enable (1 bit) and color (8 bits).
REQ-006 A write SHALL occur when WR_VALID and WR_READY are both high; it updates the shadow field only, never an active field.
REQ-007 A write with WR_FIELD 5..7 SHALL be accepted and discarded with no state change.
REQ-008 Frame start SHALL be the cycle where {X,Y}=={0,0} and the registered previous {X,Y}!={0,0}, so it is one cycle per frame regardless of pixel-enable rate.
REQ-009 FRAME_CNT SHALL increment by 1 on each frame start and wrap from 255 to 0.
REQ-010 The commit FSM SHALL have three states, with these transitions:
- IDLE -> PENDING on COMMIT.
- PENDING -> APPLY on frame start.
- APPLY -> IDLE after exactly one cycle.
REQ-011 In APPLY, all shadow slots SHALL be copied to the active slots in that single cycle.
REQ-012 WR_READY SHALL be 1 in IDLE and 0 in PENDING and APPLY, so the shadow is frozen while a commit is outstanding.
REQ-013 COMMIT_BUSY SHALL be 1 in PENDING and APPLY and 0 in IDLE.
REQ-014 COMMIT asserted in PENDING or APPLY SHALL be ignored, with no queueing.
REQ-015 A write and COMMIT in the same IDLE cycle SHALL both take effect, and the written value SHALL be included in the commit.
REQ-016 COMMIT in IDLE coinciding with a frame start SHALL go to PENDING and apply at the next frame start, never the same one.
REQ-017 Slot k SHALL hit when all of the following hold: enable=1, x0<=X<x1, and y0<=Y<y1 (half-open, unsigned 10-bit compares); x1<=x0 or y1<=y0 gives no hit.
REQ-018 Slot priority SHALL be fixed, with slot 0 highest; the pixel color is the color of the lowest-index hitting slot.
REQ-019 The pixel color SHALL be 0 when no slot hits, or when X>=H_ACTIVE or Y>=V_ACTIVE.
REQ-020 RED, GREEN and BLUE SHALL be registered, with exactly 1 cycle latency from X/Y to color.
REQ-021 Hit tests SHALL use active slots only; the APPLY cycle uses the pre-copy active values, and new values take effect on the following cycle.

Reset
REQ-022 While RST_N=0, the module SHALL reset asynchronously to these values:
- FSM in IDLE.
- All shadow and active fields 0.
- FRAME_CNT=0.
- RED=GREEN=BLUE=0.
- COMMIT_BUSY=0.
- WR_READY=1.
- Previous-{X,Y} register at {0,0}, so no frame start is detected on the first cycle after release if X=Y=0.
REQ-023 Reset asserted in PENDING or APPLY SHALL abort the commit; no partial copy remains and all slots are 0 after reset.
REQ-024 Outputs SHALL be valid from the first rising CLK edge after RST_N deasserts.

Verification
REQ-025 Write slot 0 as x0=0, x1=300, y0=0, y1=300, attr=0x1E0, then COMMIT and run 2 frames -> RED=7, GREEN=0, BLUE=0 for X<300,Y<300 from the frame after the commit start; 0 elsewhere; nothing changes before that frame start.
REQ-026 Overlap: slot 0 red at (0..300,0..300) and slot 1 green at (200..400,150..350), committed -> pixel (250,200) is red, pixel (350,200) is green, pixel (300,300) is green, pixel (400,350) is black.
REQ-027 Write, COMMIT, then WR_VALID held through PENDING -> WR_READY=0 until the cycle after APPLY; the held write is accepted then and is not visible in active until the next commit.
REQ-028 COMMIT pulsed 3 times while PENDING -> exactly one APPLY, and COMMIT_BUSY deasserts after one frame start.
REQ-029 Boundaries:
- x0=x1=100 with enable=1 -> no hit.
- X=639 inside a rect -> colored.
- X=640 -> black.
- 256 frame starts -> FRAME_CNT returns to its start value.
REQ-030 RST_N pulsed low in PENDING -> outputs 0, COMMIT_BUSY=0, WR_READY=1 immediately; a subsequent frame start causes no APPLY.
